// File: rtl/axi4_lite_slave_regfile.sv
// AXI4-Lite slave register file: NUM_REGS word registers written via AW+W, read via AR,
// always answering OKAY, with every register exposed flat on regs_o for peripheral wrappers.
module axi4_lite_slave_regfile #(
    parameter int                    ADDR_WIDTH  = 4,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    NUM_REGS    = 4,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = 32'h0000_0000
) (
    input  logic                         ACLK,
    input  logic                         ARESETn,
    input  logic [ADDR_WIDTH-1:0]        AWADDR,
    input  logic                         AWVALID,
    output logic                         AWREADY,
    input  logic [DATA_WIDTH-1:0]        WDATA,
    input  logic                         WVALID,
    output logic                         WREADY,
    output logic [1:0]                   BRESP,
    output logic                         BVALID,
    input  logic                         BREADY,
    input  logic [ADDR_WIDTH-1:0]        ARADDR,
    input  logic                         ARVALID,
    output logic                         ARREADY,
    output logic [DATA_WIDTH-1:0]        RDATA,
    output logic [1:0]                   RRESP,
    output logic                         RVALID,
    input  logic                         RREADY,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o
);

    localparam int IDX_W = ADDR_WIDTH - 2;

    typedef enum logic {WR_IDLE, WR_RESP} wr_state_t;
    typedef enum logic {RD_IDLE, RD_DATA} rd_state_t;

    wr_state_t             wr_state, wr_next;
    rd_state_t             rd_state, rd_next;
    logic                  aw_got, w_got;
    logic [IDX_W-1:0]      aw_idx;
    logic [DATA_WIDTH-1:0] w_data;
    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  commit, aw_hs, w_hs, ar_hs;
    logic                  unused_addr_bits;

    // Byte-lane bits of the addresses carry no meaning in a word-only register file.
    assign unused_addr_bits = ^{AWADDR[1:0], ARADDR[1:0]};

    // READY is gated by reset so nothing is accepted while ARESETn is low.
    assign AWREADY = ARESETn && (wr_state == WR_IDLE) && !aw_got;
    assign WREADY  = ARESETn && (wr_state == WR_IDLE) && !w_got;
    assign ARREADY = ARESETn && (rd_state == RD_IDLE);
    assign BVALID  = (wr_state == WR_RESP);
    assign RVALID  = (rd_state == RD_DATA);
    assign BRESP   = 2'b00;
    assign RRESP   = 2'b00;
    assign RDATA   = rdata_q;

    assign aw_hs  = AWVALID && AWREADY;
    assign w_hs   = WVALID && WREADY;
    assign ar_hs  = ARVALID && ARREADY;
    assign commit = (wr_state == WR_IDLE) && aw_got && w_got;

    always_comb begin
        wr_next = wr_state;
        rd_next = rd_state;
        case (wr_state)
            WR_IDLE: if (commit) wr_next = WR_RESP;
            WR_RESP: if (BREADY) wr_next = WR_IDLE;
            default: wr_next = WR_IDLE;
        endcase
        case (rd_state)
            RD_IDLE: if (ar_hs)  rd_next = RD_DATA;
            RD_DATA: if (RREADY) rd_next = RD_IDLE;
            default: rd_next = RD_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            wr_state <= WR_IDLE;
            rd_state <= RD_IDLE;
        end else begin
            wr_state <= wr_next;
            rd_state <= rd_next;
        end
    end

    // AW and W are captured independently; the write commits once both halves are held.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            aw_got <= 1'b0;
            w_got  <= 1'b0;
            aw_idx <= '0;
            w_data <= '0;
        end else begin
            if (commit) begin
                aw_got <= 1'b0;
                w_got  <= 1'b0;
            end
            if (aw_hs) begin
                aw_got <= 1'b1;
                aw_idx <= AWADDR[ADDR_WIDTH-1:2];
            end
            if (w_hs) begin
                w_got  <= 1'b1;
                w_data <= WDATA;
            end
        end
    end

    // A read sampled on the commit edge sees the pre-write register contents.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            for (int k = 0; k < NUM_REGS; k++) regs[k] <= RESET_VALUE;
            rdata_q <= '0;
        end else begin
            if (commit) regs[aw_idx] <= w_data;
            if (ar_hs)  rdata_q <= regs[ARADDR[ADDR_WIDTH-1:2]];
        end
    end

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_flat
        assign regs_o[k*DATA_WIDTH +: DATA_WIDTH] = regs[k];
    end

endmodule

// File: tb/tb_axi4_lite_slave_regfile.sv
// Bench for axi4_lite_slave_regfile: directed AXI-Lite scenarios plus random traffic, all checked
// every cycle against a transaction-level model of the register file held in queues and arrays.
module tb_axi4_lite_slave_regfile;

    logic         ACLK, ARESETn;
    logic [3:0]   AWADDR, ARADDR;
    logic         AWVALID, WVALID, BREADY, ARVALID, RREADY;
    logic [31:0]  WDATA;
    logic         AWREADY, WREADY, BVALID, ARREADY, RVALID;
    logic [1:0]   BRESP, RRESP;
    logic [31:0]  RDATA;
    logic [127:0] regs_o;

    int n_checks = 0;
    int n_fail   = 0;

    axi4_lite_slave_regfile dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
        .regs_o(regs_o)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    // Reference model: register array, queues of accepted-but-uncommitted AW/W, outstanding B/R.
    logic [31:0] m_regs [4];
    logic [31:0] m_old  [4];
    logic [3:0]  m_aw_q [$];
    logic [31:0] m_w_q  [$];
    bit          m_b_out, m_r_out;
    logic [31:0] m_rdata;
    bit          hs_aw, hs_w, hs_ar, hs_b, hs_r;
    bit          can_aw, can_w, can_ar, do_commit;

    always @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            for (int k = 0; k < 4; k++) m_regs[k] = 32'h0;
            m_aw_q.delete();
            m_w_q.delete();
            m_b_out = 0; m_r_out = 0; m_rdata = 32'h0;
            hs_aw = 0; hs_w = 0; hs_ar = 0; hs_b = 0; hs_r = 0;
        end else begin
            can_aw    = !m_b_out && (m_aw_q.size() == 0);
            can_w     = !m_b_out && (m_w_q.size() == 0);
            can_ar    = !m_r_out;
            do_commit = !m_b_out && (m_aw_q.size() > 0) && (m_w_q.size() > 0);
            m_old     = m_regs;
            hs_aw = 0; hs_w = 0; hs_ar = 0; hs_b = 0; hs_r = 0;
            if (m_b_out && BREADY) begin m_b_out = 0; hs_b = 1; end
            if (do_commit) begin
                m_regs[m_aw_q[0] >> 2] = m_w_q[0];
                void'(m_aw_q.pop_front());
                void'(m_w_q.pop_front());
                m_b_out = 1;
            end
            if (AWVALID && can_aw) begin m_aw_q.push_back(AWADDR); hs_aw = 1; end
            if (WVALID && can_w)   begin m_w_q.push_back(WDATA);   hs_w  = 1; end
            if (m_r_out && RREADY) begin m_r_out = 0; hs_r = 1; end
            if (ARVALID && can_ar) begin
                m_rdata = m_old[ARADDR >> 2];
                m_r_out = 1;
                hs_ar   = 1;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every cycle, all DUT outputs are compared against the model.
    always @(negedge ACLK) begin
        checkOutput("AWREADY", AWREADY, ARESETn && !m_b_out && (m_aw_q.size() == 0));
        checkOutput("WREADY",  WREADY,  ARESETn && !m_b_out && (m_w_q.size() == 0));
        checkOutput("ARREADY", ARREADY, ARESETn && !m_r_out);
        checkOutput("BVALID",  BVALID,  m_b_out);
        checkOutput("RVALID",  RVALID,  m_r_out);
        checkOutput("BRESP",   BRESP,   2'b00);
        checkOutput("RRESP",   RRESP,   2'b00);
        checkOutput("RDATA",   RDATA,   m_rdata);
        checkOutput("regs_o",  regs_o,  {m_regs[3], m_regs[2], m_regs[1], m_regs[0]});
    end

    function automatic bit hs_of(input int which);
        case (which)
            0: return hs_aw;
            1: return hs_w;
            2: return hs_ar;
            3: return hs_b;
            default: return hs_r;
        endcase
    endfunction

    task automatic wait_hs(input int which, input string name);
        int n;
        n = 0;
        forever begin
            @(negedge ACLK);
            if (hs_of(which)) return;
            n++;
            if (n >= 20) begin
                n_checks++;
                n_fail++;
                $display("[TB] FAIL timeout_%s: no handshake after %0d cycles, required within 20", name, n);
                return;
            end
        end
    endtask

    task automatic idle_inputs();
        AWVALID = 0; WVALID = 0; ARVALID = 0;
        AWADDR = 0; ARADDR = 0; WDATA = 0;
    endtask

    // One cycle of random AXI-legal traffic: VALID held until its handshake, READYs random.
    task automatic applyStimulus();
        @(negedge ACLK);
        if (AWVALID && hs_aw) AWVALID = 0;
        if (WVALID && hs_w)   WVALID  = 0;
        if (ARVALID && hs_ar) ARVALID = 0;
        if (!AWVALID && $urandom_range(0, 2) == 0) begin AWVALID = 1; AWADDR = 4'($urandom); end
        if (!WVALID && $urandom_range(0, 2) == 0)  begin WVALID = 1;  WDATA = $urandom; end
        if (!ARVALID && $urandom_range(0, 2) == 0) begin ARVALID = 1; ARADDR = 4'($urandom); end
        BREADY = 1'($urandom_range(0, 1));
        RREADY = 1'($urandom_range(0, 1));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time exceeded");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        ARESETn = 0; BREADY = 0; RREADY = 0;
        idle_inputs();
        repeat (3) @(negedge ACLK);
        checkOutput("rst_regs",    regs_o,  128'h0);
        checkOutput("rst_awready", AWREADY, 1'b0);
        checkOutput("rst_bvalid",  BVALID,  1'b0);
        checkOutput("rst_rvalid",  RVALID,  1'b0);
        #2 ARESETn = 1;
        #1;
        checkOutput("rel_awready", AWREADY, 1'b1);
        checkOutput("rel_wready",  WREADY,  1'b1);
        checkOutput("rel_arready", ARREADY, 1'b1);

        // AW and W on the same edge.
        @(negedge ACLK);
        AWVALID = 1; AWADDR = 4'h4; WVALID = 1; WDATA = 32'hDEAD_BEEF; BREADY = 1;
        wait_hs(0, "wr1_aw");
        idle_inputs();
        @(negedge ACLK);
        checkOutput("wr1_bvalid", BVALID, 1'b1);
        checkOutput("wr1_bresp",  BRESP,  2'b00);
        checkOutput("wr1_reg1",   regs_o[63:32], 32'hDEAD_BEEF);
        wait_hs(3, "wr1_b");

        // W three cycles ahead of AW.
        WVALID = 1; WDATA = 32'h1234_5678;
        wait_hs(1, "wr2_w");
        WVALID = 0;
        checkOutput("wr2_wready_after_w", WREADY, 1'b0);
        checkOutput("wr2_awready", AWREADY, 1'b1);
        repeat (2) @(negedge ACLK);
        AWVALID = 1; AWADDR = 4'hC;
        wait_hs(0, "wr2_aw");
        AWVALID = 0;
        checkOutput("wr2_reg3_before", regs_o[127:96], 32'h0);
        @(negedge ACLK);
        checkOutput("wr2_reg3_after", regs_o[127:96], 32'h1234_5678);
        wait_hs(3, "wr2_b");

        // Response back-pressure blocks a second write.
        BREADY = 0;
        AWVALID = 1; AWADDR = 4'h0; WVALID = 1; WDATA = 32'hA5A5_0001;
        wait_hs(0, "wr3_aw");
        AWADDR = 4'h8; WDATA = 32'h0BAD_CAFE;
        for (int i = 0; i < 5; i++) begin
            @(negedge ACLK);
            checkOutput("bp_bvalid",  BVALID,  1'b1);
            checkOutput("bp_awready", AWREADY, 1'b0);
            checkOutput("bp_wready",  WREADY,  1'b0);
        end
        checkOutput("bp_reg2_untouched", regs_o[95:64], 32'h0);
        BREADY = 1;
        wait_hs(3, "wr3_b");
        wait_hs(0, "wr4_aw");
        idle_inputs();
        wait_hs(3, "wr4_b");
        checkOutput("wr4_reg2", regs_o[95:64], 32'h0BAD_CAFE);

        // Read held by RREADY low.
        ARVALID = 1; ARADDR = 4'h4; RREADY = 0;
        wait_hs(2, "rd1_ar");
        ARVALID = 0;
        for (int i = 0; i < 4; i++) begin
            checkOutput("rd1_rvalid",  RVALID,  1'b1);
            checkOutput("rd1_rdata",   RDATA,   32'hDEAD_BEEF);
            checkOutput("rd1_arready", ARREADY, 1'b0);
            @(negedge ACLK);
        end
        RREADY = 1;
        wait_hs(4, "rd1_r");

        // Read on the commit edge returns the old value.
        RREADY = 0; BREADY = 1;
        AWVALID = 1; AWADDR = 4'h4; WVALID = 1; WDATA = 32'hCAFE_F00D;
        wait_hs(0, "col_aw");
        idle_inputs();
        ARVALID = 1; ARADDR = 4'h5;
        @(negedge ACLK);
        ARVALID = 0;
        checkOutput("col_rdata_old", RDATA, 32'hDEAD_BEEF);
        checkOutput("col_reg1_new",  regs_o[63:32], 32'hCAFE_F00D);
        RREADY = 1;
        @(negedge ACLK);
        checkOutput("col_bvalid_done", BVALID, 1'b0);
        checkOutput("col_rvalid_done", RVALID, 1'b0);
        ARVALID = 1; ARADDR = 4'h4;
        wait_hs(2, "col_reread");
        ARVALID = 0;
        checkOutput("col_reread_data", RDATA, 32'hCAFE_F00D);
        @(negedge ACLK);

        // Reset while both response channels are pending.
        BREADY = 0; RREADY = 0;
        AWVALID = 1; AWADDR = 4'h8; WVALID = 1; WDATA = 32'h0000_0077;
        ARVALID = 1; ARADDR = 4'h0;
        wait_hs(0, "rst_aw");
        idle_inputs();
        @(negedge ACLK);
        checkOutput("pre_rst_bvalid", BVALID, 1'b1);
        checkOutput("pre_rst_rvalid", RVALID, 1'b1);
        #2 ARESETn = 0;
        #1;
        checkOutput("mid_rst_bvalid", BVALID, 1'b0);
        checkOutput("mid_rst_rvalid", RVALID, 1'b0);
        checkOutput("mid_rst_regs",   regs_o, 128'h0);
        checkOutput("mid_rst_rdata",  RDATA,  32'h0);
        @(negedge ACLK);
        #2 ARESETn = 1;
        #1;
        checkOutput("post_rst_awready", AWREADY, 1'b1);

        for (int i = 0; i < 1500; i++) applyStimulus();
        @(negedge ACLK);
        idle_inputs();
        repeat (3) @(negedge ACLK);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
